// File: rtl/dac_spi_serializer.sv
// 12-bit sample to 16-bit SPI write-frame serializer for a DAC121S101-class DAC.
// Optional macro DAC_SIGNED_IN_EN: treat sample_data as two's complement (flip bit 11).
module dac_spi_serializer #(
  parameter int unsigned SCLK_DIV     = 2,
  parameter logic [1:0]  MODE         = 2'b00,
  parameter int unsigned QUIET_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sample_data,
  input  logic        sample_valid,
  input  logic        overrun_clr,
  output logic        dac_sclk,
  output logic        dac_sync_n,
  output logic        dac_din,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned DivW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int unsigned QW   = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StQuiet} state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [3:0]      bit_q, bit_d;
  logic [QW-1:0]   quiet_q, quiet_d;
  logic [15:0]     shift_q, shift_d;
  logic            pend_q, pend_d;
  logic [11:0]     pdata_q, pdata_d;
  logic            sclk_d, sync_d, din_d, ov_d, busy_d;
  logic            consume, drop;
  logic [11:0]     cap_data;

`ifdef DAC_SIGNED_IN_EN
  assign cap_data = {~sample_data[11], sample_data[10:0]};
`else
  assign cap_data = sample_data;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    quiet_d = quiet_q;
    shift_d = shift_q;
    sclk_d  = dac_sclk;
    sync_d  = dac_sync_n;
    din_d   = dac_din;
    consume = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pend_q) begin
          consume = 1'b1;
          shift_d = {2'b00, MODE, pdata_q};
          state_d = StShift;
          sync_d  = 1'b0;
          sclk_d  = 1'b1;
          din_d   = shift_d[15];
          div_d   = '0;
          bit_d   = '0;
        end
      end
      StShift: begin
        if (div_q == DivW'(SCLK_DIV - 1)) begin
          div_d  = '0;
          sclk_d = ~dac_sclk;
          // sclk currently low: this wrap is a rising edge, so present the next bit
          if (!dac_sclk) begin
            if (bit_q == 4'd15) begin
              state_d = StQuiet;
              sync_d  = 1'b1;
              sclk_d  = 1'b1;
              din_d   = 1'b0;
              quiet_d = '0;
            end else begin
              bit_d   = bit_q + 4'd1;
              shift_d = shift_q << 1;
              din_d   = shift_d[15];
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StQuiet: begin
        if (quiet_q == QW'(QUIET_CYCLES - 1)) state_d = StIdle;
        else quiet_d = quiet_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase

    drop    = sample_valid && pend_q && !consume;
    pend_d  = pend_q && !consume;
    pdata_d = pdata_q;
    if (sample_valid && !drop) begin
      pend_d  = 1'b1;
      pdata_d = cap_data;
    end
    // a drop in the same cycle as a clear keeps the flag set
    ov_d   = drop | (overrun & ~overrun_clr);
    busy_d = (state_q != StIdle) || pend_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      div_q      <= '0;
      bit_q      <= '0;
      quiet_q    <= '0;
      shift_q    <= '0;
      pend_q     <= 1'b0;
      pdata_q    <= '0;
      dac_sclk   <= 1'b1;
      dac_sync_n <= 1'b1;
      dac_din    <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      quiet_q    <= quiet_d;
      shift_q    <= shift_d;
      pend_q     <= pend_d;
      pdata_q    <= pdata_d;
      dac_sclk   <= sclk_d;
      dac_sync_n <= sync_d;
      dac_din    <= din_d;
      overrun    <= ov_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Bench for dac_spi_serializer: two configurations driven by the same random/directed
// stimulus, checked cycle by cycle against a frame-schedule model.
module tb_dac_spi_serializer;

  localparam int Q = 4;

  logic        clk, rst, sample_valid, overrun_clr;
  logic [11:0] sample_data;
  logic        sclk [2];
  logic        sync_n [2];
  logic        din [2];
  logic        busy [2];
  logic        ovr [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // model state, one entry per instance
  int          m_idle_ok [2];
  bit          m_pend [2];
  logic [11:0] m_pdata [2];
  bit          m_ov [2];
  bit          m_active [2];
  int          m_s [2];
  logic [15:0] m_w [2];
  bit          exp_busy [2];
  logic [15:0] dec [2];
  int          low_cnt [2];
  bit          prev_sync [2];
  bit          prev_sclk [2];

  dac_spi_serializer #(.SCLK_DIV(2), .MODE(2'b00), .QUIET_CYCLES(Q)) u_dut0 (
    .clk(clk), .rst(rst), .sample_data(sample_data), .sample_valid(sample_valid),
    .overrun_clr(overrun_clr), .dac_sclk(sclk[0]), .dac_sync_n(sync_n[0]),
    .dac_din(din[0]), .busy(busy[0]), .overrun(ovr[0])
  );

  dac_spi_serializer #(.SCLK_DIV(3), .MODE(2'b11), .QUIET_CYCLES(Q)) u_dut1 (
    .clk(clk), .rst(rst), .sample_data(sample_data), .sample_valid(sample_valid),
    .overrun_clr(overrun_clr), .dac_sclk(sclk[1]), .dac_sync_n(sync_n[1]),
    .dac_din(din[1]), .busy(busy[1]), .overrun(ovr[1])
  );

  always #5 clk = ~clk;

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic logic [1:0] mode_of(input int i);
    return (i == 0) ? 2'b00 : 2'b11;
  endfunction

  function automatic logic [11:0] conv(input logic [11:0] d);
`ifdef DAC_SIGNED_IN_EN
    return {~d[11], d[10:0]};
`else
    return d;
`endif
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      m_idle_ok[i] = 0;
      m_pend[i]    = 0;
      m_pdata[i]   = '0;
      m_ov[i]      = 0;
      m_active[i]  = 0;
      m_s[i]       = 0;
      m_w[i]       = '0;
      exp_busy[i]  = 0;
      dec[i]       = '0;
      low_cnt[i]   = 0;
      prev_sync[i] = 1;
      prev_sclk[i] = 1;
    end
  endtask

  // Expected pins come straight from the frame schedule: sync low for 32*D cycles from
  // the frame start, sclk high on even half-periods, bit 15-n held for half-periods 2n, 2n+1.
  task automatic check_cycle(input int i);
    int   d;
    int   k;
    logic e_sync, e_sclk, e_din;
    d      = div_of(i);
    e_sync = 1'b1;
    e_sclk = 1'b1;
    e_din  = 1'b0;
    if (m_active[i] && cyc >= m_s[i] && cyc < m_s[i] + 32 * d) begin
      k      = cyc - m_s[i];
      e_sync = 1'b0;
      e_sclk = ((k / d) % 2 == 0);
      e_din  = m_w[i][15 - k / (2 * d)];
    end
    check_eq($sformatf("i%0d_sync_n", i), sync_n[i], e_sync);
    check_eq($sformatf("i%0d_sclk", i), sclk[i], e_sclk);
    check_eq($sformatf("i%0d_din", i), din[i], e_din);
    check_eq($sformatf("i%0d_busy", i), busy[i], exp_busy[i]);
    check_eq($sformatf("i%0d_overrun", i), ovr[i], m_ov[i]);

    // frame decode as the DAC sees it: bits taken on sclk falling edges while sync is low
    if (!sync_n[i]) begin
      low_cnt[i]++;
      if (prev_sclk[i] && !sclk[i]) dec[i] = {dec[i][14:0], din[i]};
    end else if (!prev_sync[i]) begin
      check_eq($sformatf("i%0d_frame_word", i), dec[i], m_w[i]);
      check_eq($sformatf("i%0d_sync_low_len", i), low_cnt[i], 32 * d);
      low_cnt[i] = 0;
      dec[i]     = '0;
    end
    prev_sync[i] = sync_n[i];
    prev_sclk[i] = sclk[i];
  endtask

  task automatic advance(input int i, input logic v, input logic [11:0] d, input logic clr);
    int dv;
    bit was_pend, cons, drp;
    dv = div_of(i);
    exp_busy[i] = m_pend[i] || (m_active[i] && cyc >= m_s[i] && cyc < m_s[i] + 32 * dv + Q);
    was_pend = m_pend[i];
    cons     = m_pend[i] && cyc >= m_idle_ok[i];
    if (cons) begin
      m_active[i]  = 1;
      m_s[i]       = cyc + 1;
      m_w[i]       = {2'b00, mode_of(i), m_pdata[i]};
      m_idle_ok[i] = cyc + 32 * dv + Q + 1;
      m_pend[i]    = 0;
    end
    drp = v && was_pend && !cons;
    if (v && !drp) begin
      m_pend[i]  = 1;
      m_pdata[i] = conv(d);
    end
    if (drp) m_ov[i] = 1;
    else if (clr) m_ov[i] = 0;
  endtask

  task automatic step(input logic v, input logic [11:0] d, input logic clr);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_cycle(i);
      advance(i, v, d, clr);
    end
    sample_valid = v;
    sample_data  = d;
    overrun_clr  = clr;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 12'h000, 1'b0);
  endtask

  task automatic check_reset_pins(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("%s_i%0d_sync_n", tag, i), sync_n[i], 1'b1);
      check_eq($sformatf("%s_i%0d_sclk", tag, i), sclk[i], 1'b1);
      check_eq($sformatf("%s_i%0d_din", tag, i), din[i], 1'b0);
      check_eq($sformatf("%s_i%0d_busy", tag, i), busy[i], 1'b0);
      check_eq($sformatf("%s_i%0d_overrun", tag, i), ovr[i], 1'b0);
    end
  endtask

  initial begin
    clk          = 1'b0;
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample_data  = '0;
    overrun_clr  = 1'b0;
    reset_model();
    repeat (3) @(negedge clk);
    check_reset_pins("rst_init");
    rst = 1'b0;

    // single frame, then two spaced frames
    idle(3);
    step(1'b1, 12'hA5C, 1'b0);
    idle(110);
    step(1'b1, 12'h123, 1'b0);
    idle(9);
    step(1'b1, 12'h456, 1'b0);
    idle(220);

    // burst: third sample dropped, then clear, then clear coincident with a drop
    step(1'b1, 12'h111, 1'b0);
    idle(4);
    step(1'b1, 12'h222, 1'b0);
    idle(3);
    step(1'b1, 12'h333, 1'b0);
    idle(3);
    step(1'b0, 12'h000, 1'b1);
    idle(3);
    step(1'b1, 12'h444, 1'b1);
    idle(3);
    step(1'b0, 12'h000, 1'b1);
    idle(250);

    // signed-conversion corner values
    step(1'b1, 12'h800, 1'b0);
    idle(110);
    step(1'b1, 12'h7FF, 1'b0);
    idle(110);
    step(1'b1, 12'h000, 1'b0);
    idle(110);

    // random strobes and clears
    for (int n = 0; n < 2500; n++) begin
      step(($urandom_range(0, 29) == 0), 12'($urandom), ($urandom_range(0, 49) == 0));
    end
    idle(250);

    // reset mid-frame, 7 bits into the SCLK_DIV=2 frame
    step(1'b1, 12'h5A3, 1'b0);
    idle(31);
    sample_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_pins("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    idle(20);
    step(1'b1, 12'h3C6, 1'b0);
    idle(120);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
